// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between fetch and data ports with starvation protection
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              pipe_stall
);
  localparam logic [1:0] IDLE = 2'd0, GNT_IF = 2'd1, GNT_DM = 2'd2;
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  logic [1:0] state;
  logic [3:0] starve;
  logic quiet, gnt_if, gnt_dm;
  // the cycle after any completion is a bubble so the pipeline can advance its requests
  always_comb begin
    quiet  = state == IDLE && !if_done && !dm_done;
    gnt_if = quiet && if_req && (!dm_req || starve == SMAX);
    gnt_dm = quiet && dm_req && !gnt_if;
  end
  assign pipe_stall = (if_req & ~if_done) | (dm_req & ~dm_done);
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      starve    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
    end else begin
      if_done <= 1'b0;
      dm_done <= 1'b0;
      if (state == IDLE && !if_req) starve <= '0;
      if (gnt_if) begin
        state    <= GNT_IF;
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= if_addr;
        starve   <= '0;
      end else if (gnt_dm) begin
        state     <= GNT_DM;
        mem_req   <= 1'b1;
        mem_we    <= dm_we;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
        if (if_req && starve != SMAX) starve <= starve + 4'd1;
      end else if (state != IDLE && mem_ack) begin
        state   <= IDLE;
        mem_req <= 1'b0;
        if (state == GNT_IF) begin
          if_rdata <= mem_rdata;
          if_done  <= 1'b1;
        end else begin
          dm_done <= 1'b1;
          if (!mem_we) dm_rdata <= mem_rdata;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of grant order, latency, starvation, stores, reset and stray acks
module tb_mem_port_arbiter;
  logic clk = 0, rst = 1;
  logic if_req = 0, dm_req = 0, dm_we = 0, mem_ack = 0;
  logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0, mem_rdata = 0;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic if_done, dm_done, mem_req, mem_we, pipe_stall;
  int n_cmp = 0, n_err = 0;
  logic [31:0] exp_dm;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(2)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_done(if_done), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_done(dm_done), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .pipe_stall(pipe_stall));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 10 && !mem_req; i++) tick;
    check({tag, "_req_timeout"}, 32'(mem_req), 1);
  endtask

  // grant check, ack with data, then verify the right done pulse
  task automatic serve(input string tag, input logic [31:0] addr, input logic [31:0] rd, input logic is_if);
    wait_req(tag);
    check({tag, "_addr"}, mem_addr, addr);
    mem_ack = 1;
    mem_rdata = rd;
    tick;
    mem_ack = 0;
    check({tag, "_done"}, {30'd0, if_done, dm_done}, is_if ? 32'd2 : 32'd1);
  endtask

  initial begin
    tick;
    tick;
    rst = 0;
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_rdata", if_rdata | dm_rdata, 0);
    // 1: single fetch, ack in first mem_req cycle
    if_req = 1; if_addr = 32'h4;
    tick;
    check("t1_mem_req", 32'(mem_req), 1);
    check("t1_mem_addr", mem_addr, 32'h4);
    check("t1_mem_we", 32'(mem_we), 0);
    mem_ack = 1; mem_rdata = 32'h8C010000;
    tick;
    mem_ack = 0;
    check("t1_if_done", 32'(if_done), 1);
    check("t1_if_rdata", if_rdata, 32'h8C010000);
    check("t1_mem_req_drop", 32'(mem_req), 0);
    check("t1_stall", 32'(pipe_stall), 0);
    if_req = 0;
    tick;
    check("t1_done_pulse", 32'(if_done), 0);
    // 2: simultaneous requests, DM wins first
    if_req = 1; if_addr = 32'h8; dm_req = 1; dm_we = 0; dm_addr = 32'h10;
    #1 check("t2_stall", 32'(pipe_stall), 1);
    tick;
    check("t2_dm_first", mem_addr, 32'h10);
    mem_ack = 1; mem_rdata = 32'h11111111;
    tick;
    mem_ack = 0;
    check("t2_dm_done", 32'(dm_done), 1);
    check("t2_dm_rdata", dm_rdata, 32'h11111111);
    exp_dm = 32'h11111111;
    dm_req = 0;
    #1 check("t2_stall_wait_if", 32'(pipe_stall), 1);
    tick;
    check("t2_bubble", 32'(mem_req), 0);
    check("t2_stall_bubble", 32'(pipe_stall), 1);
    serve("t2_if", 32'h8, 32'h22222222, 1);
    check("t2_if_rdata", if_rdata, 32'h22222222);
    check("t2_stall_end", 32'(pipe_stall), 0);
    if_req = 0;
    tick;
    // 3: starvation with STARVE_MAX=2
    if_req = 1; if_addr = 32'h40; dm_req = 1; dm_addr = 32'h30;
    serve("t3_g1", 32'h30, 32'hA1, 0);
    serve("t3_g2", 32'h30, 32'hA2, 0);
    serve("t3_g3", 32'h40, 32'hB3, 1);
    exp_dm = 32'hA2;
    check("t3_dm_rdata", dm_rdata, exp_dm);
    if_req = 0; dm_req = 0;
    tick;
    tick;
    // 4: store with three wait cycles
    dm_req = 1; dm_we = 1; dm_addr = 32'h20; dm_wdata = 32'hDEADBEEF;
    tick;
    dm_addr = 32'h99; dm_wdata = 0;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("t4_req_c%0d", i), 32'(mem_req), 1);
      check($sformatf("t4_we_c%0d", i), 32'(mem_we), 1);
      check($sformatf("t4_addr_c%0d", i), mem_addr, 32'h20);
      check($sformatf("t4_wdata_c%0d", i), mem_wdata, 32'hDEADBEEF);
      check($sformatf("t4_nodone_c%0d", i), 32'(dm_done), 0);
      if (i == 4) begin mem_ack = 1; mem_rdata = 32'h55555555; end
      tick;
    end
    mem_ack = 0;
    check("t4_dm_done", 32'(dm_done), 1);
    check("t4_dm_rdata_kept", dm_rdata, exp_dm);
    dm_req = 0; dm_we = 0;
    tick;
    // 5: reset mid-transaction
    if_req = 1; if_addr = 32'h100;
    tick;
    check("t5_mem_req", 32'(mem_req), 1);
    rst = 1;
    tick;
    rst = 0; if_req = 0;
    check("t5_mem_req_rst", 32'(mem_req), 0);
    check("t5_if_done_rst", 32'(if_done), 0);
    check("t5_regs_rst", mem_addr | mem_wdata | if_rdata | dm_rdata, 0);
    mem_ack = 1; mem_rdata = 32'h77;
    tick;
    mem_ack = 0;
    check("t5_no_done", {30'd0, if_done, dm_done}, 0);
    // 6: stray ack while idle
    mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
    tick;
    mem_ack = 0;
    check("t6_no_done", {30'd0, if_done, dm_done}, 0);
    check("t6_no_req", 32'(mem_req), 0);
    check("t6_rdata", if_rdata | dm_rdata, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
